single_cycle_mips: RTL and testbench
====================================

Name: single_cycle_mips

Overview:
Single-cycle 32-bit MIPS subset processor. Every instruction is fetched, decoded, executed and written back in one clock cycle. It has internal instruction memory, register file and data memory, all reachable by hierarchical path so the bench can preload programs and dump state. It is the top of the processor design and has no external bus.

Parameters:
IMEM_WORDS, 256, instruction memory depth in 32-bit words.
DMEM_WORDS, 256, data memory depth in 32-bit words.
RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
clock  input  1  rising-edge system clock; must be the first port (positional instantiation).
reset_n  input  1  asynchronous active-low reset; second port.
pc_out  output  32  current PC, for debug.

Behaviour:
- Required hierarchy:
  - instance inst_mem with array memory [0:IMEM_WORDS-1] of 32 bits;
  - instance regs with array registers [0:31] of 32 bits;
  - instance data_mem with array memory [0:DMEM_WORDS-1] of 32 bits.
  - Arrays are plain unpacked regs, loadable by $readmemb and dumpable by $writememb.
- inst_mem:
  - read-only in RTL, combinational read at PC[9:2];
  - never cleared by reset (preloaded at time 0).
- Reset (reset_n low, async):
  - PC=RESET_PC, pc_out=RESET_PC;
  - all 32 registers = 0;
  - all data_mem words = 0.
  - Deassertion takes effect at the next rising clock edge.
- When reset_n is high, each rising edge:
  - commits the register write (if any);
  - commits the memory write (if any);
  - loads next PC.
- Reads are combinational within the cycle.
- Register $0 reads 0 always; writes to it are ignored.
- Next PC rules:
  - default PC+4;
  - beq/bne taken: PC+4+(sign-extended imm<<2);
  - j/jal: {PC+4[31:28], target, 2'b00};
  - jr: rs.
  - PC wraps naturally; the instruction index uses PC[9:2] modulo IMEM_WORDS.
- Supported instructions:
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00, srl 0x02, jr 0x08. Destination is rd; shifts use shamt on rt.
  - I-type: addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, bne 0x05. Destination is rt.
  - J-type: j 0x02, jal 0x03 (writes PC+4 to $31).
- Immediates:
  - sign-extended for addi, slti, lw, sw, beq, bne;
  - zero-extended for andi, ori.
- Arithmetic:
  - 32-bit two's complement, overflow ignored;
  - slt and slti are signed compares.
- Data memory:
  - word address = ALU result [9:2], modulo DMEM_WORDS; low two address bits ignored;
  - lw reads combinationally;
  - sw writes rt at the clock edge.
- Unknown opcode or funct: treated as NOP (no writes, PC+4).
- An all-zero word (sll $0,$0,0) is a NOP.
- Simultaneous events:
  - a load and a register read of the same register in later cycles see the new value;
  - within a cycle, reads see the pre-edge state.
- Reset mid-execution: PC, registers and data memory clear immediately; inst_mem is kept.

Decomposition:
- Shared package single_cycle_mips_pkg holds:
  - opcode and funct localparams;
  - ALU-control enum (ADD, SUB, AND, OR, SLT, SLL, SRL);
  - widths (XLEN=32, REG_ADDR=5).
- Sub-modules:
  - single_cycle_mips_regfile (instance regs: 2 async read ports, 1 sync write port, async clear);
  - instruction memory and data memory wrappers (instances inst_mem, data_mem);
  - control decode and ALU inline in the top level.

Test Plan:
- Reset then release with an empty (all-zero) program: after 50 cycles, PC=200, all registers and data_mem are 0.
- Run addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$1,$2; slt $5,$2,$1. Expect $1=5, $2=0xFFFFFFFD, $3=2, $4=8, $5=1.
- Run ori $1,$0,0xABCD; sw $1,8($0); lw $6,8($0). Expect data_mem[2]=0x0000ABCD and $6=0x0000ABCD.
- Loop: addi $1,$0,3; loop: addi $1,$1,-1; bne $1,$0,loop; addi $2,$0,7. Expect $1=0 and $2=7 at exit.
- Run jal to address 0x20, whose instruction is addi $7,$0,1; jr $31. Expect $31=4, $7=1, and execution resumes at 0x4.
- Run addi $0,$0,9, then assert reset_n low mid-program. Expect $0=0 throughout; reset clears PC and registers asynchronously while inst_mem contents are unchanged.

Source files
------------

// File: rtl/single_cycle_mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: datapath widths, ISA encodings,
// ALU operations and the decoded control bundle.
package single_cycle_mips_pkg;

  localparam int XLEN     = 32;
  localparam int REG_ADDR = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_op_t;

  typedef struct packed {
    logic    regWrite;
    logic    regDst;
    logic    aluSrcImm;
    logic    zeroExt;
    logic    memWrite;
    logic    memToReg;
    logic    branchEq;
    logic    branchNe;
    logic    jump;
    logic    link;
    logic    jumpReg;
    alu_op_t aluOp;
  } ctrl_t;

  function automatic logic [XLEN-1:0] extend_imm(input logic [15:0] imm, input logic zeroExt);
    return zeroExt ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/single_cycle_mips_if.sv
// Word-addressed data memory bus between the core datapath and the data memory.
interface single_cycle_mips_if
  import single_cycle_mips_pkg::*;
#(
  parameter int AW = 8
) ();

  logic [AW-1:0]   addr;
  logic [XLEN-1:0] wdata;
  logic            we;
  logic [XLEN-1:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);

endinterface

// File: rtl/single_cycle_mips_dmem.sv
// Word-addressed data memory: combinational read, write on the clock edge,
// asynchronous clear of every word.
module single_cycle_mips_dmem
  import single_cycle_mips_pkg::*;
#(
  parameter int DMEM_WORDS = 256
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  single_cycle_mips_if.slave io_bus
);

  logic [XLEN-1:0] memory [0:DMEM_WORDS-1];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        memory[i] <= '0;
      end
    end else if (io_bus.we) begin
      memory[io_bus.addr] <= io_bus.wdata;
    end
  end

  assign io_bus.rdata = memory[io_bus.addr];

endmodule

// File: rtl/single_cycle_mips_imem.sv
// Read-only instruction memory; contents are preloaded from outside and survive reset.
module single_cycle_mips_imem
  import single_cycle_mips_pkg::*;
#(
  parameter int IMEM_WORDS = 256
) (
  input  logic [$clog2(IMEM_WORDS)-1:0] i_index,
  output logic [XLEN-1:0]               o_instr
);

  logic [XLEN-1:0] memory [0:IMEM_WORDS-1];

  assign o_instr = memory[i_index];

endmodule

// File: rtl/single_cycle_mips_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one clocked write port,
// asynchronous clear. Register 0 is hard-wired to zero.
module single_cycle_mips_regfile
  import single_cycle_mips_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic [REG_ADDR-1:0] i_raddr1,
  input  logic [REG_ADDR-1:0] i_raddr2,
  input  logic                i_we,
  input  logic [REG_ADDR-1:0] i_waddr,
  input  logic [XLEN-1:0]     i_wdata,
  output logic [XLEN-1:0]     o_rdata1,
  output logic [XLEN-1:0]     o_rdata2
);

  logic [XLEN-1:0] registers [0:31];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 32; i++) begin
        registers[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      registers[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : registers[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : registers[i_raddr2];

endmodule

// File: rtl/single_cycle_mips.sv
// Single-cycle MIPS subset core: fetch, decode, execute and write back all
// complete within one clock; decode and ALU live here, storage in sub-modules.
module single_cycle_mips
  import single_cycle_mips_pkg::*;
#(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic [XLEN-1:0] pc_out
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     w_instr;
  logic [XLEN-1:0]     w_pcPlus4;
  logic [XLEN-1:0]     w_pcNext;
  logic [XLEN-1:0]     w_imm;
  logic [XLEN-1:0]     w_rsData;
  logic [XLEN-1:0]     w_rtData;
  logic [XLEN-1:0]     w_aluB;
  logic [XLEN-1:0]     w_aluResult;
  logic [XLEN-1:0]     w_wbData;
  logic [5:0]          w_opcode;
  logic [5:0]          w_funct;
  logic [REG_ADDR-1:0] w_rs;
  logic [REG_ADDR-1:0] w_rt;
  logic [REG_ADDR-1:0] w_rd;
  logic [REG_ADDR-1:0] w_waddr;
  logic [4:0]          w_shamt;
  logic [25:0]         w_target;
  logic                w_branchTaken;
  ctrl_t               w_ctrl;

  single_cycle_mips_if #(.AW(DAW)) w_dmemBus ();

  single_cycle_mips_imem #(
    .IMEM_WORDS(IMEM_WORDS)
  ) inst_mem (
    .i_index (r_pc[IAW+1:2]),
    .o_instr (w_instr)
  );

  assign w_opcode = w_instr[31:26];
  assign w_rs     = w_instr[25:21];
  assign w_rt     = w_instr[20:16];
  assign w_rd     = w_instr[15:11];
  assign w_shamt  = w_instr[10:6];
  assign w_funct  = w_instr[5:0];
  assign w_target = w_instr[25:0];

  // Unrecognised opcodes and functs leave every control bit low, which makes them NOPs.
  always_comb begin
    w_ctrl = '0;
    case (w_opcode)
      OP_RTYPE: begin
        w_ctrl.regDst   = 1'b1;
        w_ctrl.regWrite = 1'b1;
        case (w_funct)
          FN_ADD: w_ctrl.aluOp = ALU_ADD;
          FN_SUB: w_ctrl.aluOp = ALU_SUB;
          FN_AND: w_ctrl.aluOp = ALU_AND;
          FN_OR:  w_ctrl.aluOp = ALU_OR;
          FN_SLT: w_ctrl.aluOp = ALU_SLT;
          FN_SLL: w_ctrl.aluOp = ALU_SLL;
          FN_SRL: w_ctrl.aluOp = ALU_SRL;
          FN_JR: begin
            w_ctrl.regWrite = 1'b0;
            w_ctrl.jumpReg  = 1'b1;
          end
          default: w_ctrl.regWrite = 1'b0;
        endcase
      end
      OP_ADDI: begin
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.aluSrcImm = 1'b1;
      end
      OP_SLTI: begin
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.aluSrcImm = 1'b1;
        w_ctrl.aluOp     = ALU_SLT;
      end
      OP_ANDI: begin
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.aluSrcImm = 1'b1;
        w_ctrl.zeroExt   = 1'b1;
        w_ctrl.aluOp     = ALU_AND;
      end
      OP_ORI: begin
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.aluSrcImm = 1'b1;
        w_ctrl.zeroExt   = 1'b1;
        w_ctrl.aluOp     = ALU_OR;
      end
      OP_LW: begin
        w_ctrl.regWrite  = 1'b1;
        w_ctrl.aluSrcImm = 1'b1;
        w_ctrl.memToReg  = 1'b1;
      end
      OP_SW: begin
        w_ctrl.memWrite  = 1'b1;
        w_ctrl.aluSrcImm = 1'b1;
      end
      OP_BEQ: w_ctrl.branchEq = 1'b1;
      OP_BNE: w_ctrl.branchNe = 1'b1;
      OP_J:   w_ctrl.jump = 1'b1;
      OP_JAL: begin
        w_ctrl.jump     = 1'b1;
        w_ctrl.link     = 1'b1;
        w_ctrl.regWrite = 1'b1;
      end
      default: ;
    endcase
  end

  single_cycle_mips_regfile regs (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_raddr1  (w_rs),
    .i_raddr2  (w_rt),
    .i_we      (w_ctrl.regWrite),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wbData),
    .o_rdata1  (w_rsData),
    .o_rdata2  (w_rtData)
  );

  assign w_imm  = extend_imm(w_instr[15:0], w_ctrl.zeroExt);
  assign w_aluB = w_ctrl.aluSrcImm ? w_imm : w_rtData;

  // Shifts take their operand from rt and the amount from the shamt field.
  always_comb begin
    w_aluResult = '0;
    case (w_ctrl.aluOp)
      ALU_ADD: w_aluResult = w_rsData + w_aluB;
      ALU_SUB: w_aluResult = w_rsData - w_aluB;
      ALU_AND: w_aluResult = w_rsData & w_aluB;
      ALU_OR:  w_aluResult = w_rsData | w_aluB;
      ALU_SLT: w_aluResult = {{(XLEN-1){1'b0}}, ($signed(w_rsData) < $signed(w_aluB))};
      ALU_SLL: w_aluResult = w_rtData << w_shamt;
      ALU_SRL: w_aluResult = w_rtData >> w_shamt;
      default: w_aluResult = '0;
    endcase
  end

  assign w_dmemBus.addr  = w_aluResult[DAW+1:2];
  assign w_dmemBus.wdata = w_rtData;
  assign w_dmemBus.we    = w_ctrl.memWrite;

  single_cycle_mips_dmem #(
    .DMEM_WORDS(DMEM_WORDS)
  ) data_mem (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .io_bus    (w_dmemBus)
  );

  assign w_waddr  = w_ctrl.link ? REG_ADDR'(31) : (w_ctrl.regDst ? w_rd : w_rt);
  assign w_wbData = w_ctrl.link ? w_pcPlus4 :
                    (w_ctrl.memToReg ? w_dmemBus.rdata : w_aluResult);

  assign w_pcPlus4     = r_pc + XLEN'(4);
  assign w_branchTaken = (w_ctrl.branchEq && (w_rsData == w_rtData)) ||
                         (w_ctrl.branchNe && (w_rsData != w_rtData));

  always_comb begin
    w_pcNext = w_pcPlus4;
    if (w_ctrl.jumpReg) begin
      w_pcNext = w_rsData;
    end else if (w_ctrl.jump) begin
      w_pcNext = {w_pcPlus4[31:28], w_target, 2'b00};
    end else if (w_branchTaken) begin
      w_pcNext = w_pcPlus4 + {w_imm[29:0], 2'b00};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pcNext;
    end
  end

  assign pc_out = r_pc;

endmodule

// File: tb/tb_single_cycle_mips.sv
// Directed-program bench for single_cycle_mips: preloads inst_mem, runs a fixed
// number of cycles and compares registers, data memory and PC with hand-computed values.
module tb_single_cycle_mips;
  import single_cycle_mips_pkg::*;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] pc_out;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clock = ~clock;

  single_cycle_mips dut (
    .clock   (clock),
    .reset_n (reset_n),
    .pc_out  (pc_out)
  );

  // Mirror of the core's internal data memory bus, used to observe store traffic.
  single_cycle_mips_if #(.AW(8)) probe ();
  assign probe.addr  = dut.w_dmemBus.addr;
  assign probe.wdata = dut.w_dmemBus.wdata;
  assign probe.we    = dut.w_dmemBus.we;
  assign probe.rdata = dut.w_dmemBus.rdata;

  function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] shamt,
                                       input logic [5:0] fn);
    return {6'h00, rs, rt, rd, shamt, fn};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] encJ(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

  // Holds the core in reset and wipes the program so each scenario starts clean.
  task automatic applyStimulus();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) begin
      dut.inst_mem.memory[i] = 32'h0;
    end
  endtask

  task automatic runCycles(input int cycles);
    repeat (cycles) @(negedge clock);
  endtask

  task automatic releaseAndRun(input int cycles);
    @(negedge clock);
    reset_n = 1'b1;
    runCycles(cycles);
  endtask

  task automatic test_reset();
    applyStimulus();
    assertCount++;
    if (pc_out !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL reset_pc: got %h expected %h", pc_out, 32'h0);
    end
    releaseAndRun(50);
    assertCount++;
    if (pc_out !== 32'd200) begin
      failCount++;
      $display("[TB] FAIL empty_prog_pc: got %h expected %h", pc_out, 32'd200);
    end
    for (int i = 0; i < 32; i++) begin
      assertCount++;
      if (dut.regs.registers[i] !== 32'h0) begin
        failCount++;
        $display("[TB] FAIL empty_prog_reg%0d: got %h expected %h", i, dut.regs.registers[i], 32'h0);
      end
    end
    for (int i = 0; i < 256; i++) begin
      assertCount++;
      if (dut.data_mem.memory[i] !== 32'h0) begin
        failCount++;
        $display("[TB] FAIL empty_prog_dmem%0d: got %h expected %h", i, dut.data_mem.memory[i], 32'h0);
      end
    end
  endtask

  task automatic test_arith();
    logic [31:0] expVal [1:12];
    applyStimulus();
    dut.inst_mem.memory[0]  = encI(OP_ADDI, 5'd0, 5'd1, 16'd5);
    dut.inst_mem.memory[1]  = encI(OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
    dut.inst_mem.memory[2]  = encR(5'd1, 5'd2, 5'd3, 5'd0, FN_ADD);
    dut.inst_mem.memory[3]  = encR(5'd1, 5'd2, 5'd4, 5'd0, FN_SUB);
    dut.inst_mem.memory[4]  = encR(5'd2, 5'd1, 5'd5, 5'd0, FN_SLT);
    dut.inst_mem.memory[5]  = encR(5'd1, 5'd2, 5'd6, 5'd0, FN_AND);
    dut.inst_mem.memory[6]  = encR(5'd1, 5'd2, 5'd7, 5'd0, FN_OR);
    dut.inst_mem.memory[7]  = encR(5'd0, 5'd1, 5'd8, 5'd4, FN_SLL);
    dut.inst_mem.memory[8]  = encR(5'd0, 5'd2, 5'd9, 5'd28, FN_SRL);
    dut.inst_mem.memory[9]  = encI(OP_SLTI, 5'd2, 5'd10, 16'hFFFE);
    dut.inst_mem.memory[10] = encI(OP_ANDI, 5'd2, 5'd11, 16'hFF00);
    dut.inst_mem.memory[11] = encR(5'd1, 5'd2, 5'd12, 5'd0, FN_SLT);
    expVal[1]  = 32'h0000_0005;
    expVal[2]  = 32'hFFFF_FFFD;
    expVal[3]  = 32'h0000_0002;
    expVal[4]  = 32'h0000_0008;
    expVal[5]  = 32'h0000_0001;
    expVal[6]  = 32'h0000_0005;
    expVal[7]  = 32'hFFFF_FFFD;
    expVal[8]  = 32'h0000_0050;
    expVal[9]  = 32'h0000_000F;
    expVal[10] = 32'h0000_0001;
    expVal[11] = 32'h0000_FF00;
    expVal[12] = 32'h0000_0000;
    releaseAndRun(12);
    for (int r = 1; r <= 12; r++) begin
      assertCount++;
      if (dut.regs.registers[r] !== expVal[r]) begin
        failCount++;
        $display("[TB] FAIL arith_reg%0d: got %h expected %h", r, dut.regs.registers[r], expVal[r]);
      end
    end
    assertCount++;
    if (pc_out !== 32'd48) begin
      failCount++;
      $display("[TB] FAIL arith_pc: got %h expected %h", pc_out, 32'd48);
    end
  endtask

  task automatic test_memory();
    applyStimulus();
    dut.inst_mem.memory[0] = encI(OP_ORI,  5'd0, 5'd1, 16'hABCD);
    dut.inst_mem.memory[1] = encI(OP_SW,   5'd0, 5'd1, 16'd8);
    dut.inst_mem.memory[2] = encI(OP_LW,   5'd0, 5'd6, 16'd8);
    dut.inst_mem.memory[3] = encI(OP_ADDI, 5'd0, 5'd2, 16'd16);
    dut.inst_mem.memory[4] = encI(OP_SW,   5'd2, 5'd1, 16'hFFFC);
    dut.inst_mem.memory[5] = encI(OP_LW,   5'd0, 5'd7, 16'd12);
    releaseAndRun(1);
    assertCount++;
    if ({probe.we, probe.addr, probe.wdata} !== {1'b1, 8'd2, 32'h0000_ABCD}) begin
      failCount++;
      $display("[TB] FAIL sw_bus: got we=%b addr=%h wdata=%h expected we=1 addr=02 wdata=0000abcd",
               probe.we, probe.addr, probe.wdata);
    end
    runCycles(5);
    assertCount++;
    if (dut.data_mem.memory[2] !== 32'h0000_ABCD) begin
      failCount++;
      $display("[TB] FAIL sw_dmem2: got %h expected %h", dut.data_mem.memory[2], 32'h0000_ABCD);
    end
    assertCount++;
    if (dut.regs.registers[6] !== 32'h0000_ABCD) begin
      failCount++;
      $display("[TB] FAIL lw_reg6: got %h expected %h", dut.regs.registers[6], 32'h0000_ABCD);
    end
    assertCount++;
    if (dut.data_mem.memory[3] !== 32'h0000_ABCD) begin
      failCount++;
      $display("[TB] FAIL sw_negoff_dmem3: got %h expected %h", dut.data_mem.memory[3], 32'h0000_ABCD);
    end
    assertCount++;
    if (dut.regs.registers[7] !== 32'h0000_ABCD) begin
      failCount++;
      $display("[TB] FAIL lw_reg7: got %h expected %h", dut.regs.registers[7], 32'h0000_ABCD);
    end
  endtask

  task automatic test_branch();
    applyStimulus();
    dut.inst_mem.memory[0] = encI(OP_ADDI, 5'd0, 5'd1, 16'd3);
    dut.inst_mem.memory[1] = encI(OP_ADDI, 5'd1, 5'd1, 16'hFFFF);
    dut.inst_mem.memory[2] = encI(OP_BNE,  5'd1, 5'd0, 16'hFFFE);
    dut.inst_mem.memory[3] = encI(OP_ADDI, 5'd0, 5'd2, 16'd7);
    dut.inst_mem.memory[4] = encI(OP_BEQ,  5'd1, 5'd0, 16'd1);
    dut.inst_mem.memory[5] = encI(OP_ADDI, 5'd0, 5'd3, 16'd1);
    dut.inst_mem.memory[6] = encI(OP_ADDI, 5'd0, 5'd4, 16'd2);
    releaseAndRun(8);
    assertCount++;
    if ({dut.regs.registers[1], dut.regs.registers[2], pc_out} !== {32'd0, 32'd7, 32'd16}) begin
      failCount++;
      $display("[TB] FAIL loop_exit: got r1=%h r2=%h pc=%h expected r1=0 r2=7 pc=10",
               dut.regs.registers[1], dut.regs.registers[2], pc_out);
    end
    runCycles(2);
    assertCount++;
    if ({dut.regs.registers[3], dut.regs.registers[4], pc_out} !== {32'd0, 32'd2, 32'd28}) begin
      failCount++;
      $display("[TB] FAIL beq_skip: got r3=%h r4=%h pc=%h expected r3=0 r4=2 pc=1c",
               dut.regs.registers[3], dut.regs.registers[4], pc_out);
    end
  endtask

  task automatic test_jump();
    applyStimulus();
    dut.inst_mem.memory[0] = encJ(OP_JAL, 26'd8);
    dut.inst_mem.memory[1] = encI(OP_ADDI, 5'd0, 5'd8, 16'd5);
    dut.inst_mem.memory[2] = encJ(OP_J, 26'd16);
    dut.inst_mem.memory[8] = encI(OP_ADDI, 5'd0, 5'd7, 16'd1);
    dut.inst_mem.memory[9] = encR(5'd31, 5'd0, 5'd0, 5'd0, FN_JR);
    releaseAndRun(1);
    assertCount++;
    if ({pc_out, dut.regs.registers[31]} !== {32'h20, 32'h4}) begin
      failCount++;
      $display("[TB] FAIL jal: got pc=%h r31=%h expected pc=20 r31=4", pc_out, dut.regs.registers[31]);
    end
    runCycles(2);
    assertCount++;
    if ({pc_out, dut.regs.registers[7]} !== {32'h4, 32'h1}) begin
      failCount++;
      $display("[TB] FAIL jr_return: got pc=%h r7=%h expected pc=4 r7=1", pc_out, dut.regs.registers[7]);
    end
    runCycles(2);
    assertCount++;
    if ({pc_out, dut.regs.registers[8]} !== {32'h40, 32'h5}) begin
      failCount++;
      $display("[TB] FAIL j_target: got pc=%h r8=%h expected pc=40 r8=5", pc_out, dut.regs.registers[8]);
    end
  endtask

  task automatic test_nop();
    applyStimulus();
    dut.inst_mem.memory[0] = encI(6'h3F, 5'd0, 5'd1, 16'd5);
    dut.inst_mem.memory[1] = encR(5'd0, 5'd0, 5'd2, 5'd0, 6'h3F);
    releaseAndRun(3);
    assertCount++;
    if ({dut.regs.registers[1], dut.regs.registers[2], pc_out} !== {32'd0, 32'd0, 32'd12}) begin
      failCount++;
      $display("[TB] FAIL unknown_nop: got r1=%h r2=%h pc=%h expected r1=0 r2=0 pc=c",
               dut.regs.registers[1], dut.regs.registers[2], pc_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] prog [0:2];
    prog[0] = encI(OP_ADDI, 5'd0, 5'd0, 16'd9);
    prog[1] = encI(OP_ADDI, 5'd0, 5'd1, 16'd1);
    prog[2] = encI(OP_SW,   5'd0, 5'd1, 16'd0);
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      dut.inst_mem.memory[i] = prog[i];
    end
    releaseAndRun(1);
    assertCount++;
    if ({dut.regs.registers[0], dut.regs.o_rdata1} !== {32'd0, 32'd0}) begin
      failCount++;
      $display("[TB] FAIL r0_write_ignored: got reg=%h port=%h expected 0", dut.regs.registers[0], dut.regs.o_rdata1);
    end
    runCycles(2);
    assertCount++;
    if ({dut.regs.registers[1], dut.data_mem.memory[0], pc_out} !== {32'd1, 32'd1, 32'd12}) begin
      failCount++;
      $display("[TB] FAIL pre_reset_state: got r1=%h dmem0=%h pc=%h expected r1=1 dmem0=1 pc=c",
               dut.regs.registers[1], dut.data_mem.memory[0], pc_out);
    end
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    assertCount++;
    if ({pc_out, dut.regs.registers[1], dut.data_mem.memory[0]} !== {32'd0, 32'd0, 32'd0}) begin
      failCount++;
      $display("[TB] FAIL async_reset_clear: got pc=%h r1=%h dmem0=%h expected all 0",
               pc_out, dut.regs.registers[1], dut.data_mem.memory[0]);
    end
    for (int i = 0; i < 3; i++) begin
      assertCount++;
      if (dut.inst_mem.memory[i] !== prog[i]) begin
        failCount++;
        $display("[TB] FAIL imem_kept%0d: got %h expected %h", i, dut.inst_mem.memory[i], prog[i]);
      end
    end
    releaseAndRun(1);
    assertCount++;
    if ({pc_out, dut.regs.registers[0]} !== {32'd4, 32'd0}) begin
      failCount++;
      $display("[TB] FAIL restart_after_reset: got pc=%h r0=%h expected pc=4 r0=0", pc_out, dut.regs.registers[0]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3;
    test_reset();
    test_arith();
    test_memory();
    test_branch();
    test_jump();
    test_nop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
